mem_dump_reader: RTL and testbench
==================================

// Module: mem_dump_reader
// PURPOSE
// - Readback engine for the CPU instruction/data memory; the read-side counterpart of the w_instruction/w_enable/w_adrs load port.
// - While the CPU is halted (cpu_en=0), it reads a contiguous address range and streams {address, word} out over a valid/ready interface.
// - Used by benches and debug logic to dump program and result memory after a run.
// - Sits beside the memory's load port; it shares the memory through a dedicated read port (r_enable/r_adrs/r_data).
// PARAMETERS
// - ADDR_W  11  memory address width
// - DATA_W  32  memory word width
// - CNT_W   12  word_count width; must be able to hold 2^ADDR_W
// PORTS
// - clk          in   1       single clock; all logic is rising-edge
// - reset        in   1       asynchronous, active-high reset
// - cpu_en       in   1       CPU run enable; a dump is legal only while it is 0
// - start        in   1       one-cycle request; sampled only in IDLE
// - start_adrs   in   ADDR_W  first address to read
// - word_count   in   CNT_W   number of words to read
// - r_enable     out  1       memory read strobe
// - r_adrs       out  ADDR_W  memory read address
// - r_data       in   DATA_W  read data, valid exactly 1 cycle after r_enable
// - dout_valid   out  1       output word available
// - dout_ready   in   1       consumer accepts when valid & ready
// - dout_adrs    out  ADDR_W  address of dout_data
// - dout_data    out  DATA_W  memory word
// - busy         out  1       high from the cycle after start accept until done
// - done         out  1       one-cycle pulse at the end of a dump
// - aborted      out  1       level; set with done if the dump was cut short; cleared on next start accept
// - err          out  1       one-cycle pulse: start while cpu_en=1 (request ignored)
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; FIFO empty; counters 0.
// - FSM: IDLE -> READ on (start & !cpu_en & word_count!=0); IDLE -> DONE on (start & !cpu_en & word_count==0); IDLE stays IDLE on (start & cpu_en) and pulses err.
// - READ: issue one read per cycle while remaining>0 and (fifo_count + inflight) < 2; r_adrs increments by 1 mod 2^ADDR_W (0x7FF -> 0x000).
// - READ -> DRAIN when the last read has issued; DRAIN -> DONE when the FIFO is empty and no read is in flight; DONE -> IDLE after one cycle (done=1 in DONE).
// - Buffering: 2-entry FIFO of {adrs,data}; read data are captured the cycle after r_enable. Reads never issue without guaranteed space, so no data is lost under backpressure.
// - Output: dout_* come from the FIFO head; dout_valid=!empty; once valid is high, valid and the payload stay stable until the handshake.
// - Latency: first dout_valid appears 2 cycles after start accept. With dout_ready held at 1, the sustained rate is 1 word/cycle.
// - Abort: cpu_en rising while busy stops new reads at once. In-flight data and FIFO contents are discarded, the FSM goes to DONE, and aborted=1.
// - Simultaneous: a dout handshake and a FIFO write in the same cycle are both allowed, and the count is unchanged. start outside IDLE is ignored (no err).
// - reset asserted mid-dump: immediate return to the reset state; a partial stream is not resumed.
// - word_count > 2^ADDR_W: clamped to 2^ADDR_W, so each address is read at most once.
// CONFIGURATION
// - MEM_DUMP_CHECKSUM_EN defined: adds output checksum[DATA_W-1:0]. checksum = the wrapping sum of all words handshaken on dout in the current dump. It is cleared on start accept, and is valid and held from the done pulse until the next start accept. It is not updated for discarded words on abort.
// - MEM_DUMP_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour is identical.
// TESTING
// - Preload mem[15]=0xFFFF0000, mem[16]=0, mem[17]=0xAAAAAAAA; start_adrs=15, count=3, ready=1 -> (15,FFFF0000), (16,00000000), (17,AAAAAAAA) on consecutive cycles; done 1 cycle after the last handshake.
// - Same dump with ready toggling 1,0,0,1,... -> identical 3-word sequence, payload stable while stalled, never >2 reads outstanding, done after the 3rd handshake.
// - start_adrs=0x7FE, count=4 -> dout_adrs sequence 0x7FE, 0x7FF, 0x000, 0x001.
// - count=0 -> no r_enable, done pulse, aborted=0; start with cpu_en=1 -> err pulse, busy stays 0.
// - count=16, ready=0, then cpu_en=1 after 5 cycles -> r_enable drops that cycle, no further dout_valid, done pulse with aborted=1; async reset mid-dump -> all outputs 0 next edge.
// - MEM_DUMP_CHECKSUM_EN: dump of 15..17 above -> checksum=0xAAA9AAAA at done.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Halted-CPU memory readback: streams {address, word} from a contiguous range over valid/ready.
// Optional MEM_DUMP_CHECKSUM_EN adds a wrapping sum of all words accepted on dout.
module mem_dump_reader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adrs,
  input  logic [CNT_W-1:0]  word_count,
  output logic              r_enable,
  output logic [ADDR_W-1:0] r_adrs,
  input  logic [DATA_W-1:0] r_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W-1:0] dout_adrs,
  output logic [DATA_W-1:0] dout_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned      MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_remain;
  logic               r_pend;
  logic [ADDR_W-1:0]  r_pend_adrs;
  logic [ADDR_W-1:0]  r_q_adrs [2];
  logic [DATA_W-1:0]  r_q_data [2];
  logic [1:0]         r_count;
  logic [2:0]         w_occ_next;
  logic               w_accept;
  logic               w_abort;
  logic               w_pop;
  logic               w_space;
  logic               w_drained;
  logic [CNT_W-1:0]   w_count_clamped;

  assign dout_valid = (r_count != 2'd0);
  assign dout_adrs  = r_q_adrs[0];
  assign dout_data  = r_q_data[0];

  assign w_pop    = dout_valid & dout_ready;
  assign w_accept = (r_state == S_IDLE) & start & ~cpu_en;
  assign w_abort  = ((r_state == S_READ) || (r_state == S_DRAIN)) & cpu_en;

  // FIFO occupancy once this cycle's pop and returning read settle; a new read
  // may only issue if its data is guaranteed a slot when it lands.
  assign w_occ_next = 3'(r_count) + 3'(r_pend) - 3'(w_pop);
  assign w_space    = (w_occ_next < 3'd2);
  assign w_drained  = (w_occ_next == 3'd0);

  assign w_count_clamped = (word_count > MAX_CNT) ? MAX_CNT : word_count;

  always_comb begin
    w_next   = r_state;
    r_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cpu_en) w_next = (word_count == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (cpu_en) begin
          w_next = S_DONE;
        end else if (w_space && (r_remain != '0)) begin
          r_enable = 1'b1;
          if (r_remain == CNT_W'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cpu_en || w_drained) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_READ) || (w_next == S_DRAIN);
      done    <= (w_next == S_DONE);
      err     <= (r_state == S_IDLE) && start && cpu_en;
      if (w_accept)     aborted <= 1'b0;
      else if (w_abort) aborted <= 1'b1;
    end
  end

  // Read address generation and in-flight tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adrs      <= '0;
      r_remain    <= '0;
      r_pend      <= 1'b0;
      r_pend_adrs <= '0;
    end else begin
      r_pend <= r_enable;
      if (w_accept) begin
        r_adrs   <= start_adrs;
        r_remain <= w_count_clamped;
      end else if (r_enable) begin
        r_adrs      <= r_adrs + ADDR_W'(1);
        r_remain    <= r_remain - CNT_W'(1);
        r_pend_adrs <= r_adrs;
      end
    end
  end

  // Two-entry FIFO, entry 0 is the head; abort flushes it along with any returning word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_q_adrs[0] <= '0;
      r_q_adrs[1] <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
    end else if (w_abort) begin
      r_count <= 2'd0;
    end else begin
      case ({r_pend, w_pop})
        2'b10: begin
          r_q_adrs[r_count[0]] <= r_pend_adrs;
          r_q_data[r_count[0]] <= r_data;
          r_count              <= r_count + 2'd1;
        end
        2'b01: begin
          r_q_adrs[0] <= r_q_adrs[1];
          r_q_data[0] <= r_q_data[1];
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_adrs[0] <= r_pend_adrs;
            r_q_data[0] <= r_data;
          end else begin
            r_q_adrs[0] <= r_q_adrs[1];
            r_q_data[0] <= r_q_data[1];
            r_q_adrs[1] <= r_pend_adrs;
            r_q_data[1] <= r_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         checksum <= '0;
    else if (w_accept) checksum <= '0;
    else if (w_pop)    checksum <= checksum + dout_data;
  end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: expected stream model, per-cycle monitor, directed dumps.
module tb_mem_dump_reader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_en;
  logic              start;
  logic [ADDR_W-1:0] start_adrs;
  logic [CNT_W-1:0]  word_count;
  logic              r_enable;
  logic [ADDR_W-1:0] r_adrs;
  logic [DATA_W-1:0] r_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [ADDR_W-1:0] dout_adrs;
  logic [DATA_W-1:0] dout_data;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  mem_dump_reader dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .start(start),
    .start_adrs(start_adrs), .word_count(word_count),
    .r_enable(r_enable), .r_adrs(r_adrs), .r_data(r_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_adrs(dout_adrs), .dout_data(dout_data),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory with a one-cycle synchronous read port
  logic [DATA_W-1:0] mem [2048];
  always @(posedge clk) if (r_enable) r_data <= mem[r_adrs];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected stream and observation logs
  logic [ADDR_W-1:0] exp_adrs [$];
  logic [DATA_W-1:0] exp_data [$];
  logic [ADDR_W-1:0] hs_adrs_log [$];
  logic [DATA_W-1:0] hs_data_log [$];
  int                hs_cyc_log [$];
  int                rd_cnt, hs_cnt, rd_limit, first_valid, t0, dcyc;
  logic [ADDR_W-1:0] rd_next;
  logic [DATA_W-1:0] model_sum;
  bit                busy_seen, err_seen, busy_j0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int j);
    case (mode)
      0:       return 1'b1;
      1:       return (j % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int log_cyc(input int i);
    return (hs_cyc_log.size() > i) ? hs_cyc_log[i] : -1000;
  endfunction

  function automatic logic [63:0] log_ad(input int i);
    return (hs_adrs_log.size() > i) ? 64'(hs_adrs_log[i]) : 64'hBAD0;
  endfunction

  function automatic logic [63:0] log_dt(input int i);
    return (hs_data_log.size() > i) ? 64'(hs_data_log[i]) : 64'hBAD0_0000_0000;
  endfunction

  task automatic setup_model(input logic [ADDR_W-1:0] sa, input logic [CNT_W-1:0] cnt);
    logic [ADDR_W-1:0] a;
    int lim;
    lim = (int'(cnt) > 2048) ? 2048 : int'(cnt);
    exp_adrs.delete(); exp_data.delete();
    hs_adrs_log.delete(); hs_data_log.delete(); hs_cyc_log.delete();
    for (int i = 0; i < lim; i++) begin
      a = sa + ADDR_W'(i);
      exp_adrs.push_back(a);
      exp_data.push_back(mem[a]);
    end
    rd_cnt = 0; hs_cnt = 0; rd_limit = lim; rd_next = sa;
    model_sum = '0; first_valid = -1; busy_seen = 0; err_seen = 0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [CNT_W-1:0] cnt);
    @(posedge clk); #1;
    start_adrs = sa; word_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Per-cycle monitor: read addresses, stream order, credit limit, payload stability
  initial begin : monitor
    bit pv, pr, pc;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    pv = 0; pr = 0; pc = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0;
      end else begin
        if (cpu_en) chk("no_read_while_cpu_en", 64'(r_enable), 64'd0);
        if (r_enable) begin
          chk("rd_adrs", 64'(r_adrs), 64'(rd_next));
          rd_cnt++;
          rd_next = rd_next + ADDR_W'(1);
          chk("rd_within_count", 64'(rd_cnt <= rd_limit), 64'd1);
        end
        if (dout_valid && first_valid < 0) first_valid = cyc;
        if (dout_valid && dout_ready) begin
          if (exp_adrs.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_word: got adrs %0h data %0h, required no word", dout_adrs, dout_data);
          end else begin
            chk("stream_adrs", 64'(dout_adrs), 64'(exp_adrs[0]));
            chk("stream_data", 64'(dout_data), 64'(exp_data[0]));
            model_sum = model_sum + exp_data[0];
            void'(exp_adrs.pop_front());
            void'(exp_data.pop_front());
          end
          hs_cnt++;
          hs_adrs_log.push_back(dout_adrs);
          hs_data_log.push_back(dout_data);
          hs_cyc_log.push_back(cyc);
        end
        if (r_enable) chk("outstanding_le_2", 64'(rd_cnt - hs_cnt <= 2), 64'd1);
        if (pv && !pr && !pc) begin
          chk("stall_valid_held", 64'(dout_valid), 64'd1);
          chk("stall_adrs_held", 64'(dout_adrs), 64'(pa));
          chk("stall_data_held", 64'(dout_data), 64'(pd));
        end
        pv = dout_valid; pr = dout_ready; pc = cpu_en; pa = dout_adrs; pd = dout_data;
      end
    end
  end

  // Full dump with the given ready pattern; optional stray start mid-dump
  task automatic run_dump(input logic [ADDR_W-1:0] sa, input logic [CNT_W-1:0] cnt,
                          input int mode, input bit stray);
    bit got;
    int last_hs;
    setup_model(sa, cnt);
    pulse_start(sa, cnt);
    got = 0; dcyc = -1;
    for (int k = 0; k < rd_limit + 40 && !got; k++) begin
      dout_ready = rdy(mode, cyc - t0);
      if (stray && (cyc - t0) == 4) begin
        start = 1'b1; start_adrs = 11'h100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 0) busy_j0 = busy;
      if (busy) busy_seen = 1;
      if (err) err_seen = 1;
      if (done) begin
        got = 1; dcyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    last_hs = (hs_cyc_log.size() > 0) ? hs_cyc_log[$] : -1000;
    chk("done_seen", 64'(got), 64'd1);
    chk("stream_complete", 64'(exp_adrs.size()), 64'd0);
    chk("aborted_low", 64'(aborted), 64'd0);
    chk("no_err_in_dump", 64'(err_seen), 64'd0);
    if (rd_limit > 0) begin
      chk("busy_after_accept", 64'(busy_j0), 64'd1);
      chk("first_valid_latency", 64'(first_valid - t0), 64'd2);
      chk("done_after_last_hs", 64'(dcyc - last_hs), 64'd1);
      if (mode == 0) chk("full_rate", 64'(last_hs - t0), 64'(rd_limit + 1));
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(model_sum));
`endif
    @(posedge clk); #1;
    dout_ready = 1'b0;
  endtask

  // Dump of 16 words from 32, cpu_en raised in the 6th cycle after accept
  task automatic run_abort(input int mode, input int exp_hs);
    bit got;
    setup_model(11'd32, 12'd16);
    pulse_start(11'd32, 12'd16);
    for (int j = 0; j < 5; j++) begin
      dout_ready = rdy(mode, j);
      @(negedge clk);
      @(posedge clk); #1;
    end
    cpu_en = 1'b1;
    dout_ready = rdy(mode, 5);
    @(negedge clk);
    chk("abort_read_drops", 64'(r_enable), 64'd0);
    got = 0; dcyc = -1;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done) begin got = 1; dcyc = cyc; end
    end
    chk("abort_done_seen", 64'(got), 64'd1);
    chk("abort_done_cycle", 64'(dcyc - t0), 64'd6);
    chk("abort_flag", 64'(aborted), 64'd1);
    chk("abort_no_valid", 64'(dout_valid), 64'd0);
    chk("abort_busy_low", 64'(busy), 64'd0);
    chk("abort_handshakes", 64'(hs_cnt), 64'(exp_hs));
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("abort_checksum", 64'(checksum), 64'(model_sum));
`endif
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_abort_no_valid", 64'(dout_valid), 64'd0);
      chk("post_abort_flag_held", 64'(aborted), 64'd1);
    end
    @(posedge clk); #1;
    cpu_en = 1'b0; dout_ready = 1'b0;
    exp_adrs.delete(); exp_data.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_r_enable"},   64'(r_enable),   64'd0);
    chk({tag, "_r_adrs"},     64'(r_adrs),     64'd0);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_dout_adrs"},  64'(dout_adrs),  64'd0);
    chk({tag, "_dout_data"},  64'(dout_data),  64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_aborted"},    64'(aborted),    64'd0);
    chk({tag, "_err"},        64'(err),        64'd0);
  endtask

  task automatic t1_literals(input string tag);
    chk({tag, "_hs_count"}, 64'(hs_cnt), 64'd3);
    chk({tag, "_a0"}, log_ad(0), 64'h00F);
    chk({tag, "_d0"}, log_dt(0), 64'hFFFF0000);
    chk({tag, "_a1"}, log_ad(1), 64'h010);
    chk({tag, "_d1"}, log_dt(1), 64'h00000000);
    chk({tag, "_a2"}, log_ad(2), 64'h011);
    chk({tag, "_d2"}, log_dt(2), 64'hAAAAAAAA);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk({tag, "_checksum_lit"}, 64'(checksum), 64'hAAA9AAAA);
`endif
  endtask

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time budget exhausted");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) << 4) ^ 32'(i);
    mem[15] = 32'hFFFF0000;
    mem[16] = 32'h00000000;
    mem[17] = 32'hAAAAAAAA;
    reset = 1'b1; cpu_en = 1'b0; start = 1'b0; start_adrs = '0;
    word_count = '0; dout_ready = 1'b0;
    setup_model(11'd0, 12'd0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // ready held high: back-to-back words, done one cycle after the last
    run_dump(11'd15, 12'd3, 0, 1'b0);
    t1_literals("t1");
    chk("t1_hs0_cycle", 64'(log_cyc(0) - t0), 64'd2);
    chk("t1_hs2_cycle", 64'(log_cyc(2) - t0), 64'd4);
    chk("t1_done_cycle", 64'(dcyc - t0), 64'd5);

    // ready pattern 1,0,0 with a stray start that must be ignored
    run_dump(11'd15, 12'd3, 1, 1'b1);
    t1_literals("t2");
    chk("t2_hs0_cycle", 64'(log_cyc(0) - t0), 64'd3);
    chk("t2_hs1_cycle", 64'(log_cyc(1) - t0), 64'd6);
    chk("t2_hs2_cycle", 64'(log_cyc(2) - t0), 64'd9);
    chk("t2_done_cycle", 64'(dcyc - t0), 64'd10);

    // address wrap
    run_dump(11'h7FE, 12'd4, 0, 1'b0);
    chk("wrap_a0", log_ad(0), 64'h7FE);
    chk("wrap_a1", log_ad(1), 64'h7FF);
    chk("wrap_a2", log_ad(2), 64'h000);
    chk("wrap_a3", log_ad(3), 64'h001);

    // zero-length dump
    run_dump(11'd40, 12'd0, 0, 1'b0);
    chk("zero_no_reads", 64'(rd_cnt), 64'd0);
    chk("zero_no_busy", 64'(busy_seen), 64'd0);
    chk("zero_done_cycle", 64'(dcyc - t0), 64'd0);

    // start while the CPU runs
    @(posedge clk); #1;
    cpu_en = 1'b1; start = 1'b1; start_adrs = 11'd15; word_count = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy_low", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_one_cycle", 64'(err), 64'd0);
    chk("err_busy_still_low", 64'(busy), 64'd0);
    chk("err_no_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    cpu_en = 1'b0;

    // aborts under full backpressure and while streaming
    run_abort(2, 0);
    run_abort(0, 4);

    // aborted flag clears on the next accepted dump
    run_dump(11'd15, 12'd3, 0, 1'b0);
    t1_literals("t1_after_abort");

    // oversize count clamps to one pass over memory
    run_dump(11'd5, 12'hFFF, 0, 1'b0);
    chk("clamp_words", 64'(hs_cnt), 64'd2048);
    chk("clamp_last_adrs", log_ad(2047), 64'h004);

    // asynchronous reset mid-dump
    setup_model(11'd40, 12'd16);
    pulse_start(11'd40, 12'd16);
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    chk("reset_hold_valid", 64'(dout_valid), 64'd0);
    chk("reset_hold_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    chk("after_reset_idle_busy", 64'(busy), 64'd0);
    chk("after_reset_idle_valid", 64'(dout_valid), 64'd0);

    run_dump(11'd15, 12'd3, 0, 1'b0);
    t1_literals("t1_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
